code_lock_ctrl: RTL and testbench
=================================

// Module: code_lock_ctrl
// PURPOSE
//  Sequential controller for a 4-digit keypad lock, built around the 4-bit equality comparator (comp_str/comp_b/comp_d).
//  Accepts one nibble per strobe and drives comparator input A with the entered digit and input B with the stored key digit.
//  Samples comparator output Q one cycle later and accumulates a match flag across DIGITS entries.
//  Drives unlock and lockout indications to the board-level LED/relay logic.
// PARAMETERS
//  DIGITS       4         digits per code (1..8)
//  KEY          16'h6309  stored code, DIGITS*4 bits; first digit entered = KEY[3:0]
//  MAX_TRIES    3         consecutive failed codes before lockout (1..7)
//  OPEN_CYCLES  8         cycles unlocked stays high after a correct code
//  LOCK_CYCLES  16        cycles spent in lockout
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  digit_in     in   4  keypad nibble
//  digit_valid  in   1  one-cycle strobe; digit_in valid this cycle
//  clear        in   1  abort current entry
//  cmp_a        out  4  to comparator A: registered entered digit
//  cmp_b        out  4  to comparator B: key digit for current index
//  cmp_eq       in   1  from comparator Q (combinational of cmp_a/cmp_b)
//  ready        out  1  digit_valid accepted this cycle
//  unlocked     out  1  high for OPEN_CYCLES after correct code
//  locked_out   out  1  high during lockout
//  fail_cnt     out  3  consecutive failed codes
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, idx=0, match=1, cmp_a=0, cmp_b=KEY[3:0], ready=1, unlocked=0, locked_out=0, fail_cnt=0, timer=0.
//  States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT. ready=1 only in IDLE/ENTRY; digit_valid in any other state is dropped.
//  IDLE/ENTRY + digit_valid: cmp_a<=digit_in, cmp_b<=KEY[idx*4+:4], go CHECK.
//  CHECK (exactly 1 cycle): match<=match&cmp_eq; idx<=idx+1.
//   If idx==DIGITS-1 and the new match=1: fail_cnt<=0, timer<=OPEN_CYCLES-1, go OPEN.
//   If idx==DIGITS-1 and the new match=0: fail_cnt<=fail_cnt+1.
//    Failure reaching MAX_TRIES: timer<=LOCK_CYCLES-1, go LOCKOUT.
//    Otherwise go IDLE.
//   Otherwise go ENTRY.
//  Latency: the last digit's strobe at cycle t gives unlocked/locked_out high from cycle t+2.
//  OPEN: unlocked=1; timer counts down; on timer==0 go IDLE (unlocked low next cycle).
//  LOCKOUT: locked_out=1; timer counts down; on timer==0 fail_cnt<=0, go IDLE.
//  Leaving CHECK/OPEN/LOCKOUT to IDLE always sets idx<=0 and match<=1.
//  A mismatch on an early digit does not abort entry; all DIGITS digits are always taken, so no early-fail timing leak.
//  clear: honoured in ENTRY and CHECK only. It returns to IDLE with idx=0 and match=1 and is not counted as a failure.
//   clear is ignored in IDLE, OPEN and LOCKOUT.
//   clear with digit_valid in the same cycle: clear wins and the digit is dropped.
//  idx width = clog2(DIGITS), min 1; no wrap beyond DIGITS-1.
//  fail_cnt saturates at MAX_TRIES.
//  Reset mid-operation returns to the reset values immediately; no partial code survives.
// STRUCTURE
//  Shared package code_lock_pkg: state encoding localparams (IDLE=0..LOCKOUT=4), DIGIT_W=4.
//  Comparator is NOT instantiated inside; the top level wires cmp_a/cmp_b/cmp_eq to a comp_str instance.
//  One natural sub-module: lock_timer (loadable down-counter, load/en/zero).
// TESTING (bench instantiates code_lock_ctrl + comp_str, KEY=16'h6309)
//  Enter 9,0,3,6 -> unlocked=1 for exactly 8 cycles starting 2 cycles after the 4th strobe; fail_cnt=0.
//  Enter 9,0,3,7 -> unlocked stays 0, fail_cnt=1, ready=1 again after CHECK.
//  Three wrong codes (1,1,1,1 x3) -> locked_out=1 for 16 cycles; strobes are ignored (ready=0); fail_cnt=0 after exit; then 9,0,3,6 unlocks.
//  Enter 9,0 then clear together with a strobe of 3 -> IDLE, fail_cnt unchanged; 9,0,3,6 then unlocks.
//  Enter 9,0,3, assert rst_n=0 mid-CHECK -> all outputs at reset values; the next 6 alone does not unlock.
//  Check cmp_a/cmp_b on each CHECK cycle: values (9,9), (0,0), (3,3), (6,6) for the correct code.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code lock controller.
// Holds the FSM encoding, the keypad nibble width and a width helper.
// No logic; imported by the interface and every RTL module of the lock.
package code_lock_pkg;

  // Keypad nibble width and width of the consecutive-failure counter.
  localparam int DIGIT_W = 4;
  localparam int FAIL_W  = 3;

  // FSM encoding.
  localparam logic [2:0] IDLE_ENC    = 3'd0;
  localparam logic [2:0] ENTRY_ENC   = 3'd1;
  localparam logic [2:0] CHECK_ENC   = 3'd2;
  localparam logic [2:0] OPEN_ENC    = 3'd3;
  localparam logic [2:0] LOCKOUT_ENC = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = IDLE_ENC,
    ENTRY   = ENTRY_ENC,
    CHECK   = CHECK_ENC,
    OPEN    = OPEN_ENC,
    LOCKOUT = LOCKOUT_ENC
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int min1_clog2(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad-side bundle of the code lock: digit strobe/clear in, status out.
// master = keypad/board side (drives digits), slave = code_lock_ctrl.
// ready tells the keypad side whether a strobe this cycle is taken or dropped.
interface code_lock_ctrl_if;
  import code_lock_pkg::*;

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               clear;
  logic               ready;
  logic               unlocked;
  logic               locked_out;
  logic [FAIL_W-1:0]  fail_cnt;

  modport master (
    output digit_in, digit_valid, clear,
    input  ready, unlocked, locked_out, fail_cnt
  );

  modport slave (
    input  digit_in, digit_valid, clear,
    output ready, unlocked, locked_out, fail_cnt
  );

endinterface

// File: rtl/comp_str.sv
// 4-bit equality comparator used next to the code lock controller.
// Ports: a, b (4-bit operands), q (1 when a == b). Purely combinational.
// No state, no backpressure.
module comp_str (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       q
);

  assign q = (a == b);

endmodule

// File: rtl/lock_timer.sv
// Loadable down-counter for the OPEN and LOCKOUT hold times.
// Ports: clk, rst_n, load/load_val (load wins over en), en (count down), zero.
// Latency: load takes effect next cycle; the count sticks at zero.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: takes DIGITS nibbles, checks each against the key through an
// external equality comparator, then opens or counts a failure (lockout after MAX_TRIES).
// Latency: last strobe at t -> unlocked/locked_out from t+2; strobes outside IDLE/ENTRY are dropped (ready=0).
// Ports: clk, rst_n, kp (keypad bundle, slave side), cmp_a/cmp_b to the comparator, cmp_eq back from it.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                        DIGITS      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] KEY         = 16'h6309,
  parameter int                        MAX_TRIES   = 3,
  parameter int                        OPEN_CYCLES = 8,
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  code_lock_ctrl_if.slave    kp,
  output logic [DIGIT_W-1:0] cmp_a,
  output logic [DIGIT_W-1:0] cmp_b,
  input  logic               cmp_eq
);

  localparam int IW   = min1_clog2(DIGITS);
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = min1_clog2(TMAX);

  localparam logic [IW-1:0]      LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [TW-1:0]      OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]      LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  MAX_FAIL  = FAIL_W'(MAX_TRIES);
  localparam logic [DIGIT_W-1:0] KEY_FIRST = KEY[DIGIT_W-1:0];

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                match, match_nxt, match_new;
  logic [DIGIT_W-1:0]  cmp_a_nxt, cmp_b_nxt, key_digit;
  logic [FAIL_W-1:0]   fail_cnt, fail_nxt, fail_inc;
  logic                tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]       tmr_val;

  // Key digit for the position about to be entered; first digit is the low nibble.
  assign key_digit = KEY[int'(idx)*DIGIT_W +: DIGIT_W];

  // Status is a pure decode of the state register.
  assign kp.ready      = (state == IDLE) || (state == ENTRY);
  assign kp.unlocked   = (state == OPEN);
  assign kp.locked_out = (state == LOCKOUT);
  assign kp.fail_cnt   = fail_cnt;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      match    <= 1'b1;
      cmp_a    <= '0;
      cmp_b    <= KEY_FIRST;
      fail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      match    <= match_nxt;
      cmp_a    <= cmp_a_nxt;
      cmp_b    <= cmp_b_nxt;
      fail_cnt <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    match_nxt = match;
    cmp_a_nxt = cmp_a;
    cmp_b_nxt = cmp_b;
    fail_nxt  = fail_cnt;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = (state == OPEN) || (state == LOCKOUT);
    // cmp_eq reflects the digit registered on the previous cycle.
    match_new = match & cmp_eq;
    fail_inc  = (fail_cnt >= MAX_FAIL) ? fail_cnt : fail_cnt + FAIL_W'(1);

    case (state)
      IDLE: begin
        // clear has nothing to abort here, so a strobe is always taken.
        if (kp.digit_valid) begin
          cmp_a_nxt = kp.digit_in;
          cmp_b_nxt = key_digit;
          state_nxt = CHECK;
        end
      end

      ENTRY: begin
        if (kp.clear) begin
          idx_nxt   = '0;
          match_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (kp.digit_valid) begin
          cmp_a_nxt = kp.digit_in;
          cmp_b_nxt = key_digit;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (kp.clear) begin
          idx_nxt   = '0;
          match_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (idx == LAST_IDX) begin
          // Verdict only after the full code; an early mismatch just clears match.
          idx_nxt   = '0;
          match_nxt = 1'b1;
          if (match_new) begin
            fail_nxt  = '0;
            tmr_load  = 1'b1;
            tmr_val   = OPEN_LOAD;
            state_nxt = OPEN;
          end else begin
            fail_nxt = fail_inc;
            if (fail_inc >= MAX_FAIL) begin
              tmr_load  = 1'b1;
              tmr_val   = LOCK_LOAD;
              state_nxt = LOCKOUT;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          idx_nxt   = idx + IW'(1);
          match_nxt = match_new;
          state_nxt = ENTRY;
        end
      end

      OPEN: begin
        if (tmr_zero) begin
          idx_nxt   = '0;
          match_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end

      LOCKOUT: begin
        if (tmr_zero) begin
          idx_nxt   = '0;
          match_nxt = 1'b1;
          fail_nxt  = '0;
          state_nxt = IDLE;
        end
      end

      default: begin
        idx_nxt   = '0;
        match_nxt = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl wired to comp_str with KEY=16'h6309.
// Vector table + hand sequences for lockout/clear/reset, then random traffic vs a digit-queue model.
module tb_code_lock_ctrl;

  localparam int          DIGITS      = 4;
  localparam logic [15:0] KEY         = 16'h6309;
  localparam int          MAX_TRIES   = 3;
  localparam int          OPEN_CYCLES = 8;
  localparam int          LOCK_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_eq;

  int checks   = 0;
  int failures = 0;

  code_lock_ctrl_if kp();

  code_lock_ctrl #(
    .DIGITS      (DIGITS),
    .KEY         (KEY),
    .MAX_TRIES   (MAX_TRIES),
    .OPEN_CYCLES (OPEN_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .kp     (kp),
    .cmp_a  (cmp_a),
    .cmp_b  (cmp_b),
    .cmp_eq (cmp_eq)
  );

  comp_str u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .q (cmp_eq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int rdy, input int unl, input int lo,
                            input int fc, input int a, input int b);
    chk({name, ".ready"},      32'(kp.ready),      32'(rdy));
    chk({name, ".unlocked"},   32'(kp.unlocked),   32'(unl));
    chk({name, ".locked_out"}, 32'(kp.locked_out), 32'(lo));
    chk({name, ".fail_cnt"},   32'(kp.fail_cnt),   32'(fc));
    chk({name, ".cmp_a"},      32'(cmp_a),         32'(a));
    chk({name, ".cmp_b"},      32'(cmp_b),         32'(b));
  endtask

  // Apply inputs for one cycle; returns at posedge+1 with post-edge outputs visible.
  task automatic drive(input int dv, input int d, input int clr);
    kp.digit_valid = 1'(dv);
    kp.digit_in    = 4'(d);
    kp.clear       = 1'(clr);
    @(posedge clk); #1;
    kp.digit_valid = 1'b0;
    kp.clear       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic enter_digit(input int d);
    drive(1, d, 0);
    drive(0, 0, 0);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    enter_digit(d0); enter_digit(d1); enter_digit(d2); enter_digit(d3);
  endtask

  // ---------------- reference model ----------------
  // Tracks the digits typed so far and how many OPEN / LOCKOUT cycles remain.
  int   m_entered[$];
  bit   m_pending;
  int   m_open_left, m_lock_left, m_fails;
  int   m_a, m_b;

  function automatic int key_nibble(input int i);
    logic [15:0] k;
    k = KEY;
    return int'(k[i*4 +: 4]);
  endfunction

  task automatic model_reset();
    m_entered.delete();
    m_pending   = 1'b0;
    m_open_left = 0;
    m_lock_left = 0;
    m_fails     = 0;
    m_a         = 0;
    m_b         = key_nibble(0);
  endtask

  task automatic model_step(input int dv, input int d, input int clr);
    bit ok;
    if (m_open_left > 0) begin
      m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_pending) begin
      m_pending = 1'b0;
      if (clr != 0) begin
        m_entered.delete();
      end else if (m_entered.size() == DIGITS) begin
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
          if (m_entered[i] != key_nibble(i)) ok = 1'b0;
        if (ok) begin
          m_fails     = 0;
          m_open_left = OPEN_CYCLES;
        end else begin
          if (m_fails < MAX_TRIES) m_fails++;
          if (m_fails >= MAX_TRIES) m_lock_left = LOCK_CYCLES;
        end
        m_entered.delete();
      end
    end else if (clr != 0 && m_entered.size() > 0) begin
      m_entered.delete();
    end else if (dv != 0) begin
      m_a = d;
      m_b = key_nibble(m_entered.size());
      m_entered.push_back(d);
      m_pending = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       clr;
    logic       rdy, unl, lo;
    logic [2:0] fc;
    logic [3:0] a, b;
  } vec_t;

  function automatic vec_t mk(input int dv, input int d, input int clr, input int rdy,
                              input int unl, input int lo, input int fc, input int a, input int b);
    vec_t v;
    v.dv = 1'(dv); v.d = 4'(d); v.clr = 1'(clr);
    v.rdy = 1'(rdy); v.unl = 1'(unl); v.lo = 1'(lo);
    v.fc = 3'(fc); v.a = 4'(a); v.b = 4'(b);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int dv, d, clr, exp_rdy;

    // Correct code 9,0,3,6: CHECK pairs (9,9)(0,0)(3,3)(6,6), OPEN for 8 cycles.
    tbl.push_back(mk(1,9,0, 0,0,0,0, 9,9));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 9,9));
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(mk(1,3,0, 0,0,0,0, 3,3));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,3));
    tbl.push_back(mk(1,6,0, 0,0,0,0, 6,6));
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));
    tbl.push_back(mk(1,5,0, 0,1,0,0, 6,6));   // strobe while open: dropped
    tbl.push_back(mk(0,0,1, 0,1,0,0, 6,6));   // clear while open: ignored
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));
    tbl.push_back(mk(0,0,0, 0,1,0,0, 6,6));   // 8th open cycle
    tbl.push_back(mk(0,0,0, 1,0,0,0, 6,6));
    // Wrong code 9,0,3,7 with a strobe dropped during CHECK.
    tbl.push_back(mk(1,9,0, 0,0,0,0, 9,9));
    tbl.push_back(mk(1,4,0, 1,0,0,0, 9,9));
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(mk(1,3,0, 0,0,0,0, 3,3));
    tbl.push_back(mk(0,0,0, 1,0,0,0, 3,3));
    tbl.push_back(mk(1,7,0, 0,0,0,0, 7,6));
    tbl.push_back(mk(0,0,0, 1,0,0,1, 7,6));
    // clear ignored in IDLE, honoured in CHECK; next entry restarts at the first key digit.
    tbl.push_back(mk(1,9,1, 0,0,0,1, 9,9));
    tbl.push_back(mk(0,0,1, 1,0,0,1, 9,9));
    tbl.push_back(mk(1,5,0, 0,0,0,1, 5,9));
    tbl.push_back(mk(0,0,1, 1,0,0,1, 5,9));

    kp.digit_valid = 1'b0;
    kp.digit_in    = 4'd0;
    kp.clear       = 1'b0;
    model_reset();

    @(posedge clk); #1;
    check_outs("reset", 1, 0, 0, 0, 0, 9);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(int'(tbl[i].dv), int'(tbl[i].d), int'(tbl[i].clr));
      check_outs($sformatf("vec%0d", i), int'(tbl[i].rdy), int'(tbl[i].unl), int'(tbl[i].lo),
                 int'(tbl[i].fc), int'(tbl[i].a), int'(tbl[i].b));
    end

    // ---- three wrong codes -> lockout for 16 cycles ----
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      enter_code(1, 1, 1, 1);
      if (k < 3) begin
        chk($sformatf("wrong%0d.fail_cnt", k), 32'(kp.fail_cnt), 32'(k));
        chk($sformatf("wrong%0d.locked_out", k), 32'(kp.locked_out), 0);
      end
    end
    chk("lock_enter.locked_out", 32'(kp.locked_out), 1);
    chk("lock_enter.ready", 32'(kp.ready), 0);
    chk("lock_enter.fail_cnt", 32'(kp.fail_cnt), 3);
    for (int i = 1; i < LOCK_CYCLES; i++) begin
      drive(1, 9, 0);
      chk($sformatf("lock_c%0d.locked_out", i), 32'(kp.locked_out), 1);
      chk($sformatf("lock_c%0d.ready", i), 32'(kp.ready), 0);
      chk($sformatf("lock_c%0d.cmp_a", i), 32'(cmp_a), 1);
    end
    drive(0, 0, 0);
    chk("lock_exit.locked_out", 32'(kp.locked_out), 0);
    chk("lock_exit.fail_cnt", 32'(kp.fail_cnt), 0);
    chk("lock_exit.ready", 32'(kp.ready), 1);
    enter_code(9, 0, 3, 6);
    chk("after_lock.unlocked", 32'(kp.unlocked), 1);
    idle(OPEN_CYCLES - 1);
    chk("open_last.unlocked", 32'(kp.unlocked), 1);
    idle(1);
    chk("open_end.unlocked", 32'(kp.unlocked), 0);

    // ---- clear together with a strobe mid-entry ----
    do_reset();
    enter_code(1, 2, 3, 4);
    chk("pre_clear.fail_cnt", 32'(kp.fail_cnt), 1);
    enter_digit(9);
    enter_digit(0);
    drive(1, 3, 1);
    chk("clear.ready", 32'(kp.ready), 1);
    chk("clear.fail_cnt", 32'(kp.fail_cnt), 1);
    chk("clear.cmp_a", 32'(cmp_a), 0);
    enter_code(9, 0, 3, 6);
    chk("after_clear.unlocked", 32'(kp.unlocked), 1);
    chk("after_clear.fail_cnt", 32'(kp.fail_cnt), 0);
    idle(OPEN_CYCLES);

    // ---- reset asserted during CHECK of the third digit ----
    do_reset();
    enter_digit(9);
    enter_digit(0);
    drive(1, 3, 0);
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid", 1, 0, 0, 0, 0, 9);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    enter_digit(6);
    chk("rst_after.unlocked", 32'(kp.unlocked), 0);
    chk("rst_after.cmp_a", 32'(cmp_a), 6);
    chk("rst_after.cmp_b", 32'(cmp_b), 9);
    idle(2);
    chk("rst_later.unlocked", 32'(kp.unlocked), 0);

    // ---- random traffic against the model ----
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        dv  = ($urandom_range(0, 2) == 0) ? 1 : 0;
        clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
        if ($urandom_range(0, 9) < 8)
          d = key_nibble((m_entered.size() < DIGITS) ? m_entered.size() : 0);
        else
          d = int'($urandom_range(0, 15));
        drive(dv, d, clr);
        model_step(dv, d, clr);
      end
      exp_rdy = (!m_pending && m_open_left == 0 && m_lock_left == 0) ? 1 : 0;
      check_outs($sformatf("rnd%0d", cyc), exp_rdy, (m_open_left > 0) ? 1 : 0,
                 (m_lock_left > 0) ? 1 : 0, m_fails, m_a, m_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
